// File: rtl/toy_fe_rob_alloc.sv
// ----------------------------------------------------------------------------
// toy_fe_rob_alloc
// Responder side of the frontend ROB pre-allocation interface. Hands out
// fetch-ROB entry IDs in order, records icache fills per entry, and retires
// filled entries in order. A whole-ROB flush marks in-flight fills as stale so
// that their late responses are absorbed instead of corrupting a re-allocated
// entry. Only IDs and status live here; entry data is stored elsewhere.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rob_prealloc_req        allocate the entry offered on rob_prealloc_entry_id
//   rob_prealloc_entry_id   tail entry ID (next to allocate)
//   rob_rdy                 allocation accepted this cycle (combinational)
//   rob_flush               drop all allocated entries
//   icache_resp_vld/_id     fill-complete strobe and the entry it fills
//   rob_deq_vld             head entry filled and retireable (combinational)
//   rob_deq_entry_id        head entry ID
//   rob_deq_rdy             consumer accepts the head
//   rob_occupancy           number of allocated entries
// ----------------------------------------------------------------------------

package toy_pack;
    localparam int unsigned ROB_ENTRY_ID_WIDTH = 4;
endpackage

module toy_fe_rob_alloc #(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned ID_WIDTH  = toy_pack::ROB_ENTRY_ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rob_prealloc_req,
    output logic [ID_WIDTH-1:0] rob_prealloc_entry_id,
    output logic                rob_rdy,
    input  logic                rob_flush,
    input  logic                icache_resp_vld,
    input  logic [ID_WIDTH-1:0] icache_resp_entry_id,
    output logic                rob_deq_vld,
    output logic [ID_WIDTH-1:0] rob_deq_entry_id,
    input  logic                rob_deq_rdy,
    output logic [ID_WIDTH:0]   rob_occupancy
);

    localparam int unsigned PTR_W = ID_WIDTH + 1;

    // Pointers carry an extra wrap bit above the index
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [ENTRY_NUM-1:0] r_vld;
    logic [ENTRY_NUM-1:0] r_done;
    logic [ENTRY_NUM-1:0] r_stale;

    logic [ID_WIDTH-1:0]  w_head_idx;
    logic [ID_WIDTH-1:0]  w_tail_idx;
    logic                 w_full;
    logic                 w_alloc;
    logic                 w_deq;
    logic [ENTRY_NUM-1:0] w_resp_dec;
    logic [ENTRY_NUM-1:0] w_alloc_dec;
    logic [ENTRY_NUM-1:0] w_deq_dec;
    logic [ENTRY_NUM-1:0] w_pend;
    logic [ENTRY_NUM-1:0] w_fill;
    logic [ENTRY_NUM-1:0] w_absorb;

    logic [PTR_W-1:0]     w_head_nxt;
    logic [PTR_W-1:0]     w_tail_nxt;
    logic [ENTRY_NUM-1:0] w_vld_nxt;
    logic [ENTRY_NUM-1:0] w_done_nxt;
    logic [ENTRY_NUM-1:0] w_stale_nxt;

    assign w_head_idx = r_head[ID_WIDTH-1:0];
    assign w_tail_idx = r_tail[ID_WIDTH-1:0];
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[ID_WIDTH] != r_tail[ID_WIDTH]);

    // A stale entry at the tail holds allocation until its late response lands
    assign rob_rdy     = ~w_full & ~r_stale[w_tail_idx] & ~rob_flush;
    assign rob_deq_vld = r_vld[w_head_idx] & r_done[w_head_idx] & ~rob_flush;

    assign w_alloc = rob_prealloc_req & rob_rdy;
    assign w_deq   = rob_deq_vld & rob_deq_rdy;

    // One-hot entry decodes for the three per-entry events
    assign w_resp_dec  = icache_resp_vld ? (ENTRY_NUM'(1) << icache_resp_entry_id) : '0;
    assign w_alloc_dec = w_alloc ? (ENTRY_NUM'(1) << w_tail_idx) : '0;
    assign w_deq_dec   = w_deq   ? (ENTRY_NUM'(1) << w_head_idx) : '0;

    // Pending = allocated and awaiting fill; a response either fills it or,
    // on a flushed-while-pending entry, just clears the stale mark
    assign w_pend   = r_vld & ~r_done;
    assign w_fill   = w_resp_dec & w_pend;
    assign w_absorb = w_resp_dec & ~w_pend & r_stale;

    // Next-state: flush wins over allocation and dequeue
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_vld_nxt   = r_vld;
        w_done_nxt  = r_done;
        w_stale_nxt = r_stale & ~w_absorb;
        if (rob_flush) begin
            // A fill arriving in the flush cycle counts, so that entry is not stale
            w_stale_nxt = (r_stale & ~w_absorb) | (w_pend & ~w_resp_dec);
            w_vld_nxt   = '0;
            w_done_nxt  = '0;
            w_head_nxt  = r_tail;
        end else begin
            w_vld_nxt  = (r_vld & ~w_deq_dec) | w_alloc_dec;
            w_done_nxt = (r_done | w_fill) & ~w_deq_dec & ~w_alloc_dec;
            w_head_nxt = r_head + PTR_W'(w_deq);
            w_tail_nxt = r_tail + PTR_W'(w_alloc);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
            r_done  <= '0;
            r_stale <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_vld   <= w_vld_nxt;
            r_done  <= w_done_nxt;
            r_stale <= w_stale_nxt;
        end
    end

    assign rob_prealloc_entry_id = w_tail_idx;
    assign rob_deq_entry_id      = w_head_idx;
    assign rob_occupancy         = r_tail - r_head;

endmodule

// File: tb/tb_toy_fe_rob_alloc.sv
// ----------------------------------------------------------------------------
// tb_toy_fe_rob_alloc
// Self-checking bench: a vector table for the fill-to-full run, hand-written
// sequences for ordering, full+dequeue, flush/stale and async reset, then
// randomized traffic, all compared against an entry-state model.
// ----------------------------------------------------------------------------

module tb_toy_fe_rob_alloc;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [3:0] offer_id;
    logic       rdy;
    logic       flush;
    logic       rv;
    logic [3:0] rid;
    logic       deq_vld;
    logic [3:0] deq_id;
    logic       drdy;
    logic [4:0] occ;

    always #5 clk = ~clk;

    toy_fe_rob_alloc dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rob_prealloc_req      (req),
        .rob_prealloc_entry_id (offer_id),
        .rob_rdy               (rdy),
        .rob_flush             (flush),
        .icache_resp_vld       (rv),
        .icache_resp_entry_id  (rid),
        .rob_deq_vld           (deq_vld),
        .rob_deq_entry_id      (deq_id),
        .rob_deq_rdy           (drdy),
        .rob_occupancy         (occ)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: unbounded head/tail counters and a per-entry state
    typedef enum int {E_FREE, E_PEND, E_DONE} est_t;
    est_t m_st [N];
    bit   m_stale [N];
    int   m_head;
    int   m_tail;
    int   q [$];

    typedef struct {
        bit         req;
        logic [3:0] exp_id;
        bit         exp_rdy;
        logic [4:0] exp_occ;
    } vec_t;
    vec_t tbl [17];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]    = E_FREE;
            m_stale[i] = 1'b0;
        end
        m_head = 0;
        m_tail = 0;
    endfunction

    function automatic bit m_rdy();
        return ((m_tail - m_head) < N) && !m_stale[m_tail % N] && !flush;
    endfunction

    function automatic bit m_deqv();
        return (m_tail != m_head) && (m_st[m_head % N] == E_DONE) && !flush;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("offer_id", 32'(offer_id), 32'(m_tail % N));
        chk("rob_rdy",  32'(rdy),      32'(m_rdy()));
        chk("deq_vld",  32'(deq_vld),  32'(m_deqv()));
        chk("deq_id",   32'(deq_id),   32'(m_head % N));
        chk("occupancy", 32'(occ),     32'(m_tail - m_head));
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        bit a_ok;
        bit d_ok;
        a_ok = m_rdy();
        d_ok = m_deqv();
        if (rv) begin
            if (m_st[rid] == E_PEND)  m_st[rid] = E_DONE;
            else if (m_stale[rid])    m_stale[rid] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                if (m_st[i] == E_PEND) m_stale[i] = 1'b1;
                m_st[i] = E_FREE;
            end
            m_head = m_tail;
        end else begin
            if (d_ok && drdy) begin
                m_st[m_head % N] = E_FREE;
                m_head++;
            end
            if (req && a_ok) begin
                m_st[m_tail % N] = E_PEND;
                m_tail++;
            end
        end
    endtask

    task automatic drive(input bit a, input bit f, input bit v, input int id, input bit d);
        req   = a;
        flush = f;
        rv    = v;
        rid   = 4'(id);
        drdy  = d;
    endtask

    task automatic finish_cycle();
        check_model();
        model_step();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic cyc(input bit a, input bit f, input bit v, input int id, input bit d);
        drive(a, f, v, id, d);
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #12;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 17; i++) begin
            tbl[i].req     = 1'b1;
            tbl[i].exp_id  = 4'(i % 16);
            tbl[i].exp_rdy = (i < 16);
            tbl[i].exp_occ = 5'(i);
        end

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        // Fill to full: IDs 0..15 in order, refused on the 17th request
        do_reset();
        chk("reset_rdy", 32'(rdy), 32'd1);
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].req, 0, 0, 0, 0);
            @(negedge clk);
            chk("tbl_id",  32'(offer_id), 32'(tbl[i].exp_id));
            chk("tbl_rdy", 32'(rdy),      32'(tbl[i].exp_rdy));
            chk("tbl_occ", 32'(occ),      32'(tbl[i].exp_occ));
            finish_cycle();
        end

        // Out-of-order fills, in-order retire
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 0);
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("deq_vld_before_id0", 32'(deq_vld), 32'd0);
        finish_cycle();
        drive(0, 0, 1, 3, 0);
        @(negedge clk);
        chk("deq_vld_after_id0", 32'(deq_vld), 32'd1);
        finish_cycle();
        cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            chk("retire_vld", 32'(deq_vld), 32'd1);
            chk("retire_id",  32'(deq_id),  32'(i));
            finish_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drained_occ", 32'(occ), 32'd0);
        finish_cycle();

        // Full and done: dequeue frees a slot but allocation waits a cycle
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, i, 0);
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        chk("full_deq_rdy",    32'(rdy),     32'd0);
        chk("full_deq_vld",    32'(deq_vld), 32'd1);
        chk("full_deq_id",     32'(deq_id),  32'd0);
        finish_cycle();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_alloc_rdy",  32'(rdy),      32'd1);
        chk("wrap_alloc_id",   32'(offer_id), 32'd0);
        chk("wrap_alloc_occ",  32'(occ),      32'd15);
        finish_cycle();
        @(negedge clk);
        chk("refull_occ", 32'(occ), 32'd16);
        chk("refull_rdy", 32'(rdy), 32'd0);
        finish_cycle();

        // Flush with fills in flight; stale IDs 3,4,5 block the tail later
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        drive(1, 1, 1, 2, 1);
        @(negedge clk);
        chk("flush_rdy",     32'(rdy),     32'd0);
        chk("flush_deq_vld", 32'(deq_vld), 32'd0);
        finish_cycle();
        @(negedge clk);
        chk("post_flush_occ", 32'(occ),      32'd0);
        chk("post_flush_id",  32'(offer_id), 32'd6);
        finish_cycle();
        for (int i = 0; i < 13; i++) begin
            drive(1, 0, 0, 0, 0);
            @(negedge clk);
            chk("seq_id",  32'(offer_id), 32'((6 + i) % 16));
            chk("seq_rdy", 32'(rdy),      32'd1);
            finish_cycle();
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("stale_block_rdy", 32'(rdy),      32'd0);
        chk("stale_block_id",  32'(offer_id), 32'd3);
        finish_cycle();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("unblock_rdy", 32'(rdy),      32'd1);
        chk("unblock_id",  32'(offer_id), 32'd3);
        finish_cycle();

        // Stale response for 4 is absorbed; then 4 and 5 are reallocated
        cyc(0, 0, 1, 4, 0);
        @(negedge clk);
        chk("absorb_occ", 32'(occ),      32'd14);
        chk("absorb_rdy", 32'(rdy),      32'd1);
        chk("absorb_id",  32'(offer_id), 32'd4);
        finish_cycle();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, (6 + i) % 16, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            chk("drain_vld", 32'(deq_vld), 32'd1);
            chk("drain_id",  32'(deq_id),  32'((6 + i) % 16));
            finish_cycle();
        end

        // Asynchronous reset with allocated, done and stale entries present
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 4, 0);
        drive(1, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_id",      32'(offer_id), 32'd0);
        chk("arst_rdy",     32'(rdy),      32'd1);
        chk("arst_deq_vld", 32'(deq_vld),  32'd0);
        chk("arst_deq_id",  32'(deq_id),   32'd0);
        chk("arst_occ",     32'(occ),      32'd0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_arst_id",  32'(offer_id), 32'd0);
        chk("post_arst_rdy", 32'(rdy),      32'd1);
        finish_cycle();

        // Randomized traffic; responses only target pending or stale entries
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit v;
            int pick;
            q.delete();
            for (int i = 0; i < N; i++)
                if (m_st[i] == E_PEND || m_stale[i]) q.push_back(i);
            v    = (q.size() > 0) && ($urandom_range(1, 0) == 1);
            pick = (q.size() > 0) ? q[$urandom_range(q.size() - 1, 0)] : 0;
            cyc($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, v, pick,
                $urandom_range(2, 0) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
